mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage load/store sequencer for the 5-stage core. It takes the load/store intent presented by the execute stage and drives a valid/ready data-memory request bus, including byte-lane alignment. It stalls the front of the pipeline until the access completes, then returns sign- or zero-extended load data toward writeback. Misaligned, illegal and timed-out accesses are reported as single-cycle error pulses and never reach the bus.

## Interface

Parameters:
- TIMEOUT_CYCLES, default 255: maximum cycles an access may spend in REQ+RSP before it is aborted; 0 disables the watchdog.

Ports:
- clk  in  1  single core clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_mem_read  in  1  instruction is a load.
- ex_mem_write  in  1  instruction is a store.
- ex_funct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ex_addr  in  32  byte address (ALU result).
- ex_wdata  in  32  store data (rs2).
- ex_rd  in  5  load destination register.
- stall_o  out  1  hold execute/decode/fetch registers.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address, {addr[31:2], 2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rsp_valid  in  1  load response valid.
- dmem_rdata  in  32  load response word.
- load_valid  out  1  one-cycle pulse: load_data/load_rd are valid.
- load_rd  out  5  destination of the completed load.
- load_data  out  32  extended load result.
- err_o  out  1  one-cycle pulse on a misaligned, illegal or timed-out access.
- err_cause  out  2  01 misaligned, 10 illegal, 11 timeout; held until the next err_o.

## Operation

- FSM states: IDLE, REQ, RSP.
- start = state==IDLE & ex_valid & (ex_mem_read | ex_mem_write).
- Illegal condition: ex_mem_read & ex_mem_write both high, or funct3 in {011, 110, 111} (stores additionally reject 100 and 101).
  - Behaviour: err_o pulse with cause 10, no bus access, no stall, stay IDLE.
- Misaligned condition: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Behaviour: err_o pulse with cause 01, no bus access, no stall, stay IDLE.
- A legal start captures addr, funct3, wdata, rd and the we flag into request registers, then moves IDLE->REQ.
- REQ: dmem_req_valid=1, with payload driven from the request registers and stable until dmem_req_ready.
  - On handshake, a store moves to IDLE and completes.
  - On handshake, a load moves to RSP.
- RSP: dmem_req_valid=0. On dmem_rsp_valid:
  - select the byte/half at lane addr[1:0];
  - sign-extend (B, H) or zero-extend (BU, HU);
  - register the result into load_data/load_rd, pulse load_valid, return to IDLE.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{d[7:0]}}.
  - SH: be=0011<<addr[1:0], wdata={2{d[15:0]}}.
  - SW: be=1111, wdata=d.
  - dmem_be=0 when not in REQ.
- Watchdog: the counter clears on start and increments each cycle in REQ/RSP.
  - When count==TIMEOUT_CYCLES-1 and the access does not complete that cycle: err_o pulse with cause 11, dmem_req_valid drops, return to IDLE.
  - Completion in the same cycle as expiry wins, and no error is raised.
- dmem_rsp_valid in IDLE/REQ is ignored, including stale responses after reset or timeout.

## Timing

- Reset values: state=IDLE. All of dmem_req_valid, dmem_we, dmem_be, stall_o, load_valid, err_o = 0. err_cause=00. dmem_addr, dmem_wdata, load_data = 0. load_rd=0. Counter=0.
- stall_o is combinational: start_legal | (state==REQ & !(ready & we)) | (state==RSP & !rsp_valid). It is low in the completion cycle, so the upstream stage advances on that edge.
- Store latency: request appears 1 cycle after start. Done on the ready edge, so a minimum of 2 cycles of occupancy.
- Load latency: load_valid pulses 1 cycle after rsp_valid, so a minimum of 3 cycles after start.
- err_o and load_valid are registered and appear the cycle after the triggering condition.
- rst_n assertion mid-access aborts immediately. Outputs take reset values asynchronously, with no completion or error reported.

## Structure

- core_pkg holds:
  - the mem_width_e funct3 encodings (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU);
  - the mem_state_e enum (IDLE, REQ, RSP);
  - the err_cause localparams.
- One sub-module, mem_lane_align: purely combinational store replication/byte-enable generation and load extraction/extension, shared with future cache paths.
- The FSM, request registers, watchdog and output registers live in mem_access_ctrl.

## Test plan

- Store word, addr=0x100, data=0xDEADBEEF, ready held low 3 cycles -> dmem_be=1111, dmem_addr=0x100 with payload stable 4 cycles, stall_o high until the ready cycle, no load_valid.
- SB at addr=0x103 with d=0x000000A5 -> dmem_be=1000, dmem_wdata=0xA5A5A5A5, dmem_addr=0x100.
- LB at addr=0x202, rdata=0x12F03456, rsp after 2 wait cycles -> load_data=0xFFFFFFF0. The same access as LBU gives 0x000000F0, with load_rd echoed.
- LW at addr=0x302 -> err_o with cause 01, no dmem_req_valid, stall_o low. funct3=011 gives cause 10.
- TIMEOUT_CYCLES=4, load with rsp never arriving -> err_o cause 11 with state back in IDLE. A later stray rsp_valid gives no load_valid.
- rst_n low while in RSP -> all outputs zero immediately. After release, a new store completes normally.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the memory stage: access widths, sequencer states, error causes.
package core_pkg;

    // funct3 encodings for load/store width and signedness
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_width_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RSP  = 2'b10
    } mem_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // Unsigned widths only make sense for loads.
    function automatic logic width_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        case (f3)
            MEM_B, MEM_H, MEM_W: ok = 1'b1;
            MEM_BU, MEM_HU:      ok = ~is_store;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3)
            MEM_H, MEM_HU: bad = lo[0];
            MEM_W:         bad = (lo != 2'b00);
            default:       bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication/byte enables and load extraction/extension.
module mem_lane_align
    import core_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [31:0] o_store_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_load_data
);

    logic [31:0] w_shifted;

    // Store side: replicate the datum into every lane it could occupy, enable only its lanes.
    always_comb begin
        o_store_data = i_store_data;
        o_be         = 4'b1111;
        case (i_funct3)
            MEM_B, MEM_BU: begin
                o_store_data = {4{i_store_data[7:0]}};
                o_be         = 4'b0001 << i_addr_lo;
            end
            MEM_H, MEM_HU: begin
                o_store_data = {2{i_store_data[15:0]}};
                o_be         = 4'b0011 << i_addr_lo;
            end
            default: ;
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then sign- or zero-extend.
    always_comb begin
        w_shifted   = i_load_word >> {i_addr_lo, 3'b000};
        o_load_data = i_load_word;
        case (i_funct3)
            MEM_B:   o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            MEM_H:   o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MEM_BU:  o_load_data = {24'h0, w_shifted[7:0]};
            MEM_HU:  o_load_data = {16'h0, w_shifted[15:0]};
            default: o_load_data = i_load_word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store sequencer: drives the dmem valid/ready bus, stalls the
// front end while an access is in flight, returns extended load data and flags errors.
module mem_access_ctrl
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        stall_o,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        load_valid,
    output logic [4:0]  load_rd,
    output logic [31:0] load_data,
    output logic        err_o,
    output logic [1:0]  err_cause
);

    // Counter only ever needs to reach TIMEOUT_CYCLES-1.
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax =
        CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    mem_state_e     r_state, w_state_next;
    logic [31:0]    r_addr, r_wdata;
    logic [2:0]     r_funct3;
    logic [4:0]     r_rd;
    logic           r_we;
    logic [CntW-1:0] r_cnt;
    logic           r_load_valid, r_err;
    logic [4:0]     r_load_rd;
    logic [31:0]    r_load_data;
    logic [1:0]     r_err_cause;

    logic        w_start, w_illegal, w_misaligned, w_start_legal;
    logic        w_in_req, w_in_rsp, w_rsp_done, w_complete, w_timeout;
    logic        w_err_next;
    logic [1:0]  w_cause_next;
    logic [31:0] w_store_data, w_load_ext;
    logic [3:0]  w_be;

    mem_lane_align u_lane_align (
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_addr[1:0]),
        .i_store_data (r_wdata),
        .i_load_word  (dmem_rdata),
        .o_store_data (w_store_data),
        .o_be         (w_be),
        .o_load_data  (w_load_ext)
    );

    // Decode the incoming request and the in-flight completion/expiry conditions.
    always_comb begin
        w_start       = (r_state == IDLE) & ex_valid & (ex_mem_read | ex_mem_write);
        w_illegal     = (ex_mem_read & ex_mem_write) | ~width_legal(ex_funct3, ex_mem_write);
        w_misaligned  = addr_misaligned(ex_funct3, ex_addr[1:0]);
        w_start_legal = w_start & ~w_illegal & ~w_misaligned;
        w_in_req      = (r_state == REQ);
        w_in_rsp      = (r_state == RSP);
        w_rsp_done    = w_in_rsp & dmem_rsp_valid;
        // A load handshake is progress, not completion; only store accept or response completes.
        w_complete    = (w_in_req & dmem_req_ready & r_we) | w_rsp_done;
        w_timeout     = (TIMEOUT_CYCLES != 0) & (w_in_req | w_in_rsp)
                        & (r_cnt == CntMax) & ~w_complete;
        w_err_next    = (w_start & (w_illegal | w_misaligned)) | w_timeout;
        if (w_start & w_illegal) begin
            w_cause_next = ERR_ILLEGAL;
        end else if (w_start & w_misaligned) begin
            w_cause_next = ERR_MISALIGN;
        end else begin
            w_cause_next = ERR_TIMEOUT;
        end
    end

    // Next-state logic for the IDLE/REQ/RSP sequencer.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start_legal) w_state_next = REQ;
            end
            REQ: begin
                if (w_timeout) begin
                    w_state_next = IDLE;
                end else if (dmem_req_ready) begin
                    w_state_next = r_we ? IDLE : RSP;
                end
            end
            RSP: begin
                if (dmem_rsp_valid || w_timeout) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request capture and watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_funct3 <= 3'b000;
            r_rd     <= 5'd0;
            r_we     <= 1'b0;
            r_cnt    <= '0;
        end else if (w_start_legal) begin
            r_addr   <= ex_addr;
            r_wdata  <= ex_wdata;
            r_funct3 <= ex_funct3;
            r_rd     <= ex_rd;
            r_we     <= ex_mem_write;
            r_cnt    <= '0;
        end else if (w_in_req | w_in_rsp) begin
            r_cnt    <= r_cnt + CntW'(1);
        end
    end

    // Registered result and error pulses; err_cause holds until the next error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_valid <= 1'b0;
            r_load_rd    <= 5'd0;
            r_load_data  <= 32'h0;
            r_err        <= 1'b0;
            r_err_cause  <= ERR_NONE;
        end else begin
            r_load_valid <= w_rsp_done;
            r_err        <= w_err_next;
            if (w_rsp_done) begin
                r_load_rd   <= r_rd;
                r_load_data <= w_load_ext;
            end
            if (w_err_next) r_err_cause <= w_cause_next;
        end
    end

    // Bus and pipeline-facing outputs.
    always_comb begin
        stall_o        = w_start_legal | (w_in_req & ~(dmem_req_ready & r_we))
                         | (w_in_rsp & ~dmem_rsp_valid);
        dmem_req_valid = w_in_req;
        dmem_we        = w_in_req & r_we;
        dmem_addr      = {r_addr[31:2], 2'b00};
        dmem_wdata     = w_store_data;
        dmem_be        = w_in_req ? w_be : 4'b0000;
        load_valid     = r_load_valid;
        load_rd        = r_load_rd;
        load_data      = r_load_data;
        err_o          = r_err;
        err_cause      = r_err_cause;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a short watchdog (TIMEOUT_CYCLES=4).
module tb_mem_access_ctrl;

    logic        clk, rst_n;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall_o, dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_rsp_valid, load_valid, err_o;
    logic [4:0]  load_rd;
    logic [31:0] load_data;
    logic [1:0]  err_cause;

    int n_tests;
    int n_fail;

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_funct3      (ex_funct3),
        .ex_addr        (ex_addr),
        .ex_wdata       (ex_wdata),
        .ex_rd          (ex_rd),
        .stall_o        (stall_o),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .load_valid     (load_valid),
        .load_rd        (load_rd),
        .load_data      (load_data),
        .err_o          (err_o),
        .err_cause      (err_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rdst);
        ex_valid     = 1'b1;
        ex_mem_read  = rd;
        ex_mem_write = wr;
        ex_funct3    = f3;
        ex_addr      = a;
        ex_wdata     = d;
        ex_rd        = rdst;
    endtask

    task automatic idle_ex();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    // Load with immediate accept, `waits` idle RSP cycles, then the response word.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [4:0] rdst, input logic [31:0] word, input int waits,
                            input logic [31:0] exp);
        issue(1'b1, 1'b0, f3, a, 32'h0, rdst);
        step();
        idle_ex();
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b1;          // stale response while in REQ must be ignored
        dmem_rdata     = 32'hFFFF_FFFF;
        #1;
        check_eq({tag, "_req"}, 32'(dmem_req_valid), 32'h1);
        check_eq({tag, "_we"}, 32'(dmem_we), 32'h0);
        check_eq({tag, "_req_stall"}, 32'(stall_o), 32'h1);
        step();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        for (int i = 0; i < waits; i++) begin
            #1;
            check_eq({tag, "_wait_stall"}, 32'(stall_o), 32'h1);
            check_eq({tag, "_wait_noreq"}, 32'(dmem_req_valid), 32'h0);
            step();
        end
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = word;
        #1;
        check_eq({tag, "_rsp_stall"}, 32'(stall_o), 32'h0);
        check_eq({tag, "_rsp_lv_early"}, 32'(load_valid), 32'h0);
        step();
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;
        #1;
        check_eq({tag, "_lv"}, 32'(load_valid), 32'h1);
        check_eq({tag, "_data"}, load_data, exp);
        check_eq({tag, "_rd"}, 32'(load_rd), 32'(rdst));
        check_eq({tag, "_noerr"}, 32'(err_o), 32'h0);
        step();
        #1;
        check_eq({tag, "_lv_pulse"}, 32'(load_valid), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got 0x%08h, want 0x%08h", 1, 0);
        $fatal(1, "simulation time limit");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        idle_ex();
        ex_funct3 = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = 32'h0;

        // Reset values
        step();
        check_eq("rst_stall", 32'(stall_o), 32'h0);
        check_eq("rst_req", 32'(dmem_req_valid), 32'h0);
        check_eq("rst_we", 32'(dmem_we), 32'h0);
        check_eq("rst_be", 32'(dmem_be), 32'h0);
        check_eq("rst_addr", dmem_addr, 32'h0);
        check_eq("rst_wdata", dmem_wdata, 32'h0);
        check_eq("rst_lv", 32'(load_valid), 32'h0);
        check_eq("rst_lrd", 32'(load_rd), 32'h0);
        check_eq("rst_ldata", load_data, 32'h0);
        check_eq("rst_err", 32'(err_o), 32'h0);
        check_eq("rst_cause", 32'(err_cause), 32'h0);
        step();
        rst_n = 1'b1;

        // SW 0x100, ready low for 3 cycles; accept lands on the last watchdog cycle
        step();
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0);
        #1;
        check_eq("sw_start_stall", 32'(stall_o), 32'h1);
        check_eq("sw_start_noreq", 32'(dmem_req_valid), 32'h0);
        step();
        idle_ex();
        for (int i = 0; i < 4; i++) begin
            dmem_req_ready = (i == 3);
            #1;
            check_eq("sw_req", 32'(dmem_req_valid), 32'h1);
            check_eq("sw_be", 32'(dmem_be), 32'hF);
            check_eq("sw_addr", dmem_addr, 32'h100);
            check_eq("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
            check_eq("sw_we", 32'(dmem_we), 32'h1);
            check_eq("sw_stall", 32'(stall_o), 32'(i != 3));
            step();
        end
        dmem_req_ready = 1'b0;
        #1;
        check_eq("sw_done_req", 32'(dmem_req_valid), 32'h0);
        check_eq("sw_done_be", 32'(dmem_be), 32'h0);
        check_eq("sw_done_noerr", 32'(err_o), 32'h0);
        check_eq("sw_done_nolv", 32'(load_valid), 32'h0);
        check_eq("sw_done_stall", 32'(stall_o), 32'h0);

        // SB 0x103
        issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 5'd0);
        step();
        idle_ex();
        dmem_req_ready = 1'b1;
        #1;
        check_eq("sb_be", 32'(dmem_be), 32'h8);
        check_eq("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        check_eq("sb_addr", dmem_addr, 32'h100);
        check_eq("sb_stall", 32'(stall_o), 32'h0);
        step();
        dmem_req_ready = 1'b0;
        #1;
        check_eq("sb_done_req", 32'(dmem_req_valid), 32'h0);

        // Loads
        run_load("lb", 3'b000, 32'h202, 5'd5, 32'h12F0_3456, 2, 32'hFFFF_FFF0);
        run_load("lbu", 3'b100, 32'h202, 5'd9, 32'h12F0_3456, 0, 32'h0000_00F0);
        run_load("lh", 3'b001, 32'h202, 5'd12, 32'h8001_7FFE, 1, 32'hFFFF_8001);
        run_load("lhu", 3'b101, 32'h200, 5'd13, 32'h8001_FFFE, 0, 32'h0000_FFFE);
        run_load("lw", 3'b010, 32'h204, 5'd31, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);

        // Misaligned / illegal
        issue(1'b1, 1'b0, 3'b010, 32'h302, 32'h0, 5'd1);
        #1;
        check_eq("mis_lw_stall", 32'(stall_o), 32'h0);
        step();
        idle_ex();
        #1;
        check_eq("mis_lw_err", 32'(err_o), 32'h1);
        check_eq("mis_lw_cause", 32'(err_cause), 32'h1);
        check_eq("mis_lw_noreq", 32'(dmem_req_valid), 32'h0);
        check_eq("mis_lw_nostall", 32'(stall_o), 32'h0);
        step();
        #1;
        check_eq("mis_err_pulse", 32'(err_o), 32'h0);
        check_eq("mis_cause_held", 32'(err_cause), 32'h1);
        issue(1'b1, 1'b0, 3'b011, 32'h300, 32'h0, 5'd1);
        #1;
        check_eq("ill_f3_stall", 32'(stall_o), 32'h0);
        step();
        idle_ex();
        #1;
        check_eq("ill_f3_err", 32'(err_o), 32'h1);
        check_eq("ill_f3_cause", 32'(err_cause), 32'h2);
        issue(1'b0, 1'b1, 3'b100, 32'h300, 32'h0, 5'd0);
        step();
        idle_ex();
        #1;
        check_eq("ill_sbu_cause", 32'(err_cause), 32'h2);
        check_eq("ill_sbu_noreq", 32'(dmem_req_valid), 32'h0);
        issue(1'b1, 1'b1, 3'b010, 32'h300, 32'h0, 5'd0);
        step();
        idle_ex();
        #1;
        check_eq("ill_rw_err", 32'(err_o), 32'h1);
        check_eq("ill_rw_cause", 32'(err_cause), 32'h2);
        issue(1'b0, 1'b1, 3'b001, 32'h301, 32'h0, 5'd0);
        step();
        idle_ex();
        #1;
        check_eq("mis_sh_cause", 32'(err_cause), 32'h1);
        check_eq("mis_sh_noreq", 32'(dmem_req_valid), 32'h0);
        step();
        #1;
        check_eq("err_quiet", 32'(err_o), 32'h0);

        // Load timeout in RSP, then a stray response
        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd3);
        step();
        idle_ex();
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        step();
        step();
        #1;
        check_eq("to_ld_last_stall", 32'(stall_o), 32'h1);
        check_eq("to_ld_last_noerr", 32'(err_o), 32'h0);
        step();
        #1;
        check_eq("to_ld_err", 32'(err_o), 32'h1);
        check_eq("to_ld_cause", 32'(err_cause), 32'h3);
        check_eq("to_ld_stall", 32'(stall_o), 32'h0);
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h0000_0055;
        #1;
        check_eq("stray_stall", 32'(stall_o), 32'h0);
        step();
        dmem_rsp_valid = 1'b0;
        #1;
        check_eq("stray_nolv", 32'(load_valid), 32'h0);
        check_eq("stray_ldata", load_data, 32'hCAFE_F00D);

        // Store timeout in REQ
        issue(1'b0, 1'b1, 3'b010, 32'h500, 32'h1111_1111, 5'd0);
        step();
        idle_ex();
        step();
        step();
        step();
        #1;
        check_eq("to_st_req", 32'(dmem_req_valid), 32'h1);
        step();
        #1;
        check_eq("to_st_err", 32'(err_o), 32'h1);
        check_eq("to_st_cause", 32'(err_cause), 32'h3);
        check_eq("to_st_noreq", 32'(dmem_req_valid), 32'h0);
        check_eq("to_st_be", 32'(dmem_be), 32'h0);

        // Reset while waiting in RSP
        issue(1'b1, 1'b0, 3'b000, 32'h600, 32'h0, 5'd7);
        step();
        idle_ex();
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        #1;
        check_eq("rrsp_stall", 32'(stall_o), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("rrsp_stall0", 32'(stall_o), 32'h0);
        check_eq("rrsp_req0", 32'(dmem_req_valid), 32'h0);
        check_eq("rrsp_addr0", dmem_addr, 32'h0);
        check_eq("rrsp_cause0", 32'(err_cause), 32'h0);
        check_eq("rrsp_ldata0", load_data, 32'h0);
        check_eq("rrsp_lrd0", 32'(load_rd), 32'h0);
        check_eq("rrsp_lv0", 32'(load_valid), 32'h0);
        check_eq("rrsp_err0", 32'(err_o), 32'h0);
        step();
        rst_n = 1'b1;
        dmem_rsp_valid = 1'b1;
        step();
        dmem_rsp_valid = 1'b0;
        #1;
        check_eq("rrsp_stale_nolv", 32'(load_valid), 32'h0);

        // Fresh store after reset
        issue(1'b0, 1'b1, 3'b001, 32'h502, 32'h0000_1234, 5'd0);
        step();
        idle_ex();
        dmem_req_ready = 1'b1;
        #1;
        check_eq("post_sh_be", 32'(dmem_be), 32'hC);
        check_eq("post_sh_wdata", dmem_wdata, 32'h1234_1234);
        check_eq("post_sh_addr", dmem_addr, 32'h500);
        step();
        dmem_req_ready = 1'b0;
        #1;
        check_eq("post_sh_done", 32'(dmem_req_valid), 32'h0);
        check_eq("post_sh_noerr", 32'(err_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
